// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: BITS_PER_CYCLE full-adder slices per clock, carry kept in a register.
// Optional subtraction port enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int BPC = BITS_PER_CYCLE;
    localparam int K   = WIDTH / BPC;
    localparam int CW  = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(K - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;
    logic [BPC-1:0]   w_chunk_sum;
    logic             w_c_msb;
    logic             w_c_out;
    logic [WIDTH-1:0] w_res_next;

    // Operand conditioning at accept time: subtraction becomes a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        w_b_load   = sub ? ~b : b;
        w_cin_load = sub ? 1'b1 : cin;
`else
        w_b_load   = b;
        w_cin_load = cin;
`endif
    end

    // Chained full-adder slice over the low BPC bits; w_c_msb ends as the carry into the slice's top bit.
    always_comb begin : slice
        logic c;
        c           = r_carry;
        w_chunk_sum = '0;
        w_c_msb     = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            w_chunk_sum[i] = r_a[i] ^ r_b[i] ^ c;
            w_c_msb        = c;
            c              = (r_a[i] & r_b[i]) | (c & (r_a[i] ^ r_b[i]));
        end
        w_c_out = c;
    end

    // Partial sums enter at the MSB end so the last chunk leaves the result aligned.
    assign w_res_next = WIDTH'({w_chunk_sum, r_res} >> BPC);

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_cin_load;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> BPC;
                    r_b     <= r_b >> BPC;
                    r_carry <= w_c_out;
                    r_res   <= w_res_next;
                    if (r_cnt == LAST_CHUNK) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c_out;
                        r_ovf   <= w_c_msb ^ w_c_out;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
